// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - registered MIPS write-back stage with load formatting and retire counter
module wb_stage_pipe #(
    parameter int DATA_W            = 32,
    parameter int REG_ADDR_W        = 5,
    parameter bit ZERO_REG_SUPPRESS = 1'b1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_stall,
    input  logic                  in_flush,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_wb_sel,
    input  logic [1:0]            in_mem_size,
    input  logic                  in_mem_unsigned,
    input  logic [REG_ADDR_W-1:0] in_write_back_destination,
    input  logic [DATA_W-1:0]     in_address,
    input  logic [DATA_W-1:0]     in_read_data,
    input  logic [DATA_W-1:0]     in_link_pc,
    output logic [DATA_W-1:0]     wb_out,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] write_back_destination_out,
    output logic                  wb_valid_out,
    output logic                  misalign_out,
    output logic [CNT_W-1:0]      retire_count_out
);

    // Byte offset of the access inside one DATA_W word (2 bits for 32, 3 bits for 64).
    localparam int OFF_W = $clog2(DATA_W / 8);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] half_off;
    logic [OFF_W-1:0] word_off;
    logic [OFF_W+2:0] byte_base;
    logic [OFF_W+2:0] half_base;
    logic [OFF_W+2:0] word_base;

    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       word_v;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] result;
    logic              misalign_raw;
    logic              dest_is_zero;
    logic              write_en;

    logic [DATA_W-1:0]     wb_q,    wb_d;
    logic                  rw_q,    rw_d;
    logic [REG_ADDR_W-1:0] dest_q,  dest_d;
    logic                  valid_q, valid_d;
    logic                  mis_q,   mis_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    // Lane selection: half and word lanes are naturally aligned by masking low offset bits,
    // so a misaligned access still returns the containing aligned lane.
    assign off       = in_address[OFF_W-1:0];
    assign half_off  = off & ~OFF_W'(1);
    assign word_off  = off & ~OFF_W'(3);
    assign byte_base = {off, 3'b000};
    assign half_base = {half_off, 3'b000};
    assign word_base = {word_off, 3'b000};

    // Extract the addressed lane and extend it to the datapath width.
    always_comb begin
        byte_v   = in_read_data[byte_base +: 8];
        half_v   = in_read_data[half_base +: 16];
        word_v   = in_read_data[word_base +: 32];
        load_ext = in_read_data;
        case (in_mem_size)
            SZ_BYTE: load_ext = in_mem_unsigned ? DATA_W'(byte_v) : DATA_W'($signed(byte_v));
            SZ_HALF: load_ext = in_mem_unsigned ? DATA_W'(half_v) : DATA_W'($signed(half_v));
            SZ_WORD: load_ext = in_mem_unsigned ? DATA_W'(word_v) : DATA_W'($signed(word_v));
            default: load_ext = in_read_data;
        endcase
    end

    // Alignment fault only matters for memory-sourced half and word loads.
    always_comb begin
        misalign_raw = 1'b0;
        if (in_wb_sel == SEL_MEM) begin
            if (in_mem_size == SZ_HALF) begin
                misalign_raw = off[0];
            end else if (in_mem_size == SZ_WORD) begin
                misalign_raw = (off[1:0] != 2'b00);
            end
        end
    end

    // Write-back source mux; the unused encoding falls back to the ALU result.
    always_comb begin
        case (in_wb_sel)
            SEL_ALU:  result = in_address;
            SEL_MEM:  result = load_ext;
            SEL_LINK: result = in_link_pc;
            default:  result = in_address;
        endcase
    end

    assign dest_is_zero = (in_write_back_destination == '0);
    assign write_en     = in_valid & in_reg_write & ~(ZERO_REG_SUPPRESS & dest_is_zero);

    // Next-state: flush kills the instruction but keeps data/address, stall holds everything.
    always_comb begin
        wb_d    = wb_q;
        rw_d    = rw_q;
        dest_d  = dest_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        if (in_flush) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mis_d   = 1'b0;
        end else if (!in_stall) begin
            wb_d    = result;
            dest_d  = in_write_back_destination;
            valid_d = in_valid;
            rw_d    = write_en;
            mis_d   = misalign_raw & in_valid;
            if (write_en && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stage registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q    <= '0;
            rw_q    <= 1'b0;
            dest_q  <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wb_q    <= wb_d;
            rw_q    <= rw_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_out                     = wb_q;
    assign reg_write_out              = rw_q;
    assign write_back_destination_out = dest_q;
    assign wb_valid_out               = valid_q;
    assign misalign_out               = mis_q;
    assign retire_count_out           = cnt_q;

endmodule
